// File: rtl/seq_add_sub.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per clock, LSB slice first.
// Optional saturation of result on carry/borrow-out when SEQ_ADD_SUB_SAT_EN is defined.
module seq_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $fatal(1, "seq_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             mode_reg;

  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] b_slice;
  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] final_result;
  logic             last_slice;
  logic             raw_bout;
  logic             raw_ovf;

  // Subtraction runs as a + ~b + ~bin, so the chain always carries; borrow = !carry.
  assign a_slice   = a_reg[DIGIT-1:0];
  assign b_slice   = mode_reg ? b_reg[DIGIT-1:0] : ~b_reg[DIGIT-1:0];
  assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry_reg};

  assign last_slice = (cnt_reg == CW'(N - 1));
  assign raw_bout   = mode_reg ? slice_sum[DIGIT] : ~slice_sum[DIGIT];
  // Only meaningful on the last slice, where the operand MSBs sit at the slice top.
  assign raw_ovf    = (a_slice[DIGIT-1] == b_slice[DIGIT-1]) &&
                      (slice_sum[DIGIT-1] != a_slice[DIGIT-1]);

  // Drop the current slice sum into its position, keeping earlier slices.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign sum_next[gi*DIGIT +: DIGIT] = (cnt_reg == CW'(gi)) ?
                                           slice_sum[DIGIT-1:0] :
                                           sum_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

`ifdef SEQ_ADD_SUB_SAT_EN
  assign final_result = raw_bout ? (mode_reg ? {WIDTH{1'b1}} : {WIDTH{1'b0}}) : sum_next;
`else
  assign final_result = sum_next;
`endif

  // busy/done follow the state one cycle later, so done pulses the cycle after DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      mode_reg  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      busy <= (state_reg == RUN);
      done <= (state_reg == DONE);
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            sum_reg   <= '0;
            mode_reg  <= mode;
            carry_reg <= mode ? bin : ~bin;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          sum_reg   <= sum_next;
          carry_reg <= slice_sum[DIGIT];
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_slice) begin
            state_reg <= DONE;
            result    <= final_result;
            bout      <= raw_bout;
            ovf       <= raw_ovf;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed bench for seq_add_sub: 8-bit serial instance plus an exhaustive 4-bit / 2-bit-digit instance.
// Expected results follow SEQ_ADD_SUB_SAT_EN when that macro is defined.
module tb_seq_add_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, mode8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] result8;

  logic       start4 = 1'b0, mode4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] result4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .result(result8), .bout(bout8), .ovf(ovf8)
  );

  seq_add_sub #(.WIDTH(4), .DIGIT(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .result(result4), .bout(bout4), .ovf(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation to the 8-bit instance for exactly one start edge.
  task automatic launch8(input logic m, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    mode8  = m;
    a8     = av;
    b8     = bv;
    bin8   = bi;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy8, done8, result8, bout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_dut8: busy=%b done=%b result=%h bout=%b ovf=%b, required all 0",
               busy8, done8, result8, bout8, ovf8);
    end
    checks++;
    if ({busy4, done4, result4, bout4, ovf4} !== 8'h00) begin
      errors++;
      $display("FAIL reset_dut4: busy=%b done=%b result=%h bout=%b ovf=%b, required all 0",
               busy4, done4, result4, bout4, ovf4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    launch8(1'b0, 8'h35, 8'h12, 1'b0);
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL latency_start_edge: busy=%b done=%b, required busy=0 done=0", busy8, done8);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
        errors++;
        $display("FAIL latency_run_%0d: busy=%b done=%b, required busy=1 done=0", i, busy8, done8);
      end
    end
    tick();
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || result8 !== 8'h23 || bout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL latency_done: done=%b busy=%b result=%h bout=%b ovf=%b, required 1 0 23 0 0",
               done8, busy8, result8, bout8, ovf8);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || result8 !== 8'h23) begin
      errors++;
      $display("FAIL latency_after_done: done=%b result=%h, required done=0 result=23", done8, result8);
    end
  endtask

  task automatic test_vectors();
    logic       tm [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ta [10] = '{8'h35, 8'h00, 8'h7F, 8'hFF, 8'h80, 8'h10, 8'h05, 8'h40, 8'h80, 8'h12};
    logic [7:0] tb [10] = '{8'h12, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0F, 8'h05, 8'h40, 8'h80, 8'h34};
    logic       tc [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] tr [10] = '{8'h23, 8'hFF, 8'h80, 8'h01, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h47};
    logic       to [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       tv [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_r;
    for (int t = 0; t < 10; t++) begin
      exp_r = tr[t];
`ifdef SEQ_ADD_SUB_SAT_EN
      if (to[t]) exp_r = tm[t] ? 8'hFF : 8'h00;
`endif
      launch8(tm[t], ta[t], tb[t], tc[t]);
      // Scramble the inputs mid-operation; the latched operands must win.
      mode8 = ~tm[t];
      a8    = ~ta[t];
      b8    = ta[t];
      bin8  = ~tc[t];
      for (int i = 0; i < 9; i++) tick();
      checks++;
      if (done8 !== 1'b1 || result8 !== exp_r || bout8 !== to[t] || ovf8 !== tv[t]) begin
        errors++;
        $display("FAIL vector_%0d mode=%b a=%h b=%h bin=%b: done=%b result=%h bout=%b ovf=%b, required 1 %h %b %b",
                 t, tm[t], ta[t], tb[t], tc[t], done8, result8, bout8, ovf8, exp_r, to[t], tv[t]);
      end
      tick();
    end
  endtask

  task automatic test_start_mid_run();
    logic extra_done = 1'b0;
    launch8(1'b1, 8'h12, 8'h34, 1'b1);
    tick();
    tick();
    tick();
    mode8 = 1'b0; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_early_done: done=%b, required 0", done8);
    end
    tick();
    checks++;
    if (done8 !== 1'b1 || result8 !== 8'h47 || bout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_done: done=%b result=%h bout=%b ovf=%b, required 1 47 0 0",
               done8, result8, bout8, ovf8);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0) extra_done = 1'b1;
    end
    checks++;
    if (extra_done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_queued: extra activity=%b, required 0 (ignored start must not run)", extra_done);
    end
  endtask

  task automatic test_back_to_back();
    logic extra_done = 1'b0;
    launch8(1'b0, 8'h35, 8'h12, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    mode8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; bin8 = 1'b0;
    start8 = 1'b1;
    tick();
    checks++;
    if (done8 !== 1'b1 || result8 !== 8'h23) begin
      errors++;
      $display("FAIL b2b_first: done=%b result=%h, required 1 23", done8, result8);
    end
    a8 = 8'h00; b8 = 8'h00;
    tick();
    start8 = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (done8 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap_%0d: done=%b, required 0", i, done8);
      end
    end
    tick();
    checks++;
    if (done8 !== 1'b1 || result8 !== 8'h80 || bout8 !== 1'b0 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: done=%b result=%h bout=%b ovf=%b, required 1 80 0 1",
               done8, result8, bout8, ovf8);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8 !== 1'b0) extra_done = 1'b1;
    end
    checks++;
    if (extra_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_third: extra done=%b, required 0", extra_done);
    end
  endtask

  task automatic test_reset_mid_run();
    logic saw_done = 1'b0;
    launch8(1'b1, 8'hFF, 8'h01, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, result8, bout8, ovf8} !== 12'h000) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b result=%h bout=%b ovf=%b, required all 0",
               busy8, done8, result8, bout8, ovf8);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: activity=%b, required 0", saw_done);
    end
    launch8(1'b0, 8'h35, 8'h12, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart_early: done=%b, required 0", done8);
    end
    tick();
    checks++;
    if (done8 !== 1'b1 || result8 !== 8'h23 || bout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: done=%b result=%h bout=%b ovf=%b, required 1 23 0 0",
               done8, result8, bout8, ovf8);
    end
    tick();
  endtask

  task automatic test_exhaustive_w4();
    int   sa, sb, t, u;
    logic [3:0] exp_r;
    logic exp_b, exp_o, early;
    for (int m = 0; m < 2; m++)
      for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++)
          for (int ci = 0; ci < 2; ci++) begin
            sa = (av >= 8) ? av - 16 : av;
            sb = (bv >= 8) ? bv - 16 : bv;
            if (m == 1) begin
              u = av + bv + ci;
              t = sa + sb + ci;
              exp_b = (u > 15);
            end else begin
              u = av - bv - ci;
              t = sa - sb - ci;
              exp_b = (av < bv + ci);
            end
            exp_r = 4'(u & 15);
            exp_o = (t > 7) || (t < -8);
`ifdef SEQ_ADD_SUB_SAT_EN
            if (exp_b) exp_r = (m == 1) ? 4'hF : 4'h0;
`endif
            mode4 = 1'(m); a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(ci);
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            a4 = ~a4;
            tick();
            early = done4;
            tick();
            early = early | done4;
            tick();
            checks++;
            if (early !== 1'b0 || done4 !== 1'b1 || result4 !== exp_r || bout4 !== exp_b || ovf4 !== exp_o) begin
              errors++;
              $display("FAIL w4 mode=%0d a=%h b=%h bin=%0d: early=%b done=%b result=%h bout=%b ovf=%b, required 0 1 %h %b %b",
                       m, av, bv, ci, early, done4, result4, bout4, ovf4, exp_r, exp_b, exp_o);
            end
          end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_start_mid_run();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive_w4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_add_sub.md
SEQ_ADD_SUB -- requirements
Module: seq_add_sub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; WIDTH SHALL be at least 2.
REQ-002 Parameter DIGIT, default 1: bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT, otherwise elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request; SHALL be sampled on the rising edge of clk.
REQ-006 mode  input  1  operation select: 0 = subtract, 1 = add.
REQ-007 a  input  WIDTH  minuend or augend.
REQ-008 b  input  WIDTH  subtrahend or addend.
REQ-009 bin  input  1  borrow-in (subtract) or carry-in (add).
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result  output  WIDTH  final result.
REQ-013 bout  output  1  borrow-out (subtract) or carry-out (add).
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 States SHALL be IDLE, RUN and DONE; N = WIDTH/DIGIT.
REQ-016 In IDLE or DONE, start=1 SHALL latch a, b, bin and mode, clear the digit counter and enter RUN.
REQ-017 In RUN, each cycle SHALL process the next DIGIT-bit slice, LSB slice first, and propagate the borrow or carry to the next slice.
REQ-018 RUN SHALL last exactly N cycles, then enter DONE; DONE SHALL last one cycle, then enter IDLE unless start=1 is accepted.
REQ-019 Latency: for start sampled at edge k, busy SHALL be 1 after edges k+1..k+N and done SHALL be 1 only after edge k+N+1.
REQ-020 Subtract: result SHALL be (a - b - bin) mod 2^WIDTH; bout SHALL be 1 exactly when a < b + bin (unsigned).
REQ-021 Add: result SHALL be (a + b + bin) mod 2^WIDTH; bout SHALL be the carry out of bit WIDTH-1.
REQ-022 ovf SHALL be 1 when the signed interpretation of the raw result differs from the true signed result.
REQ-023 result, bout and ovf SHALL update only on the edge that enters DONE, and SHALL hold until the next completion.
REQ-024 Input changes after the start edge SHALL NOT affect an operation in progress.
REQ-025 start=1 in RUN SHALL be ignored; no queuing.
REQ-026 start=1 in DONE SHALL be accepted, giving back-to-back operations with done high every N+1 cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE and set busy, done, result, bout and ovf to 0, the digit counter to 0 and the operand registers to 0.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n returns to 1 SHALL behave as in REQ-016.

Configuration
REQ-029 Macro SEQ_ADD_SUB_SAT_EN: when defined, a subtract with bout=1 SHALL produce result 0, and an add with bout=1 SHALL produce result all ones.
REQ-030 With SEQ_ADD_SUB_SAT_EN, bout and ovf SHALL still reflect the raw, unsaturated operation.
REQ-031 Without SEQ_ADD_SUB_SAT_EN, result SHALL be the modular value and no saturation logic SHALL exist.

Verification
REQ-032 WIDTH=8, DIGIT=1: subtract a=0x35, b=0x12, bin=0 -> result 0x23, bout 0, ovf 0; done exactly 9 cycles after the start edge, busy high for 8 cycles.
REQ-033 Subtract a=0x00, b=0x01, bin=0 -> result 0xFF, bout 1, ovf 0; with SEQ_ADD_SUB_SAT_EN -> result 0x00, bout 1.
REQ-034 Add a=0x7F, b=0x01, bin=0 -> result 0x80, bout 0, ovf 1; add a=0xFF, b=0x01, bin=1 -> result 0x01, bout 1, ovf 0.
REQ-035 start pulsed mid-RUN -> ignored, result unchanged; start held high on the done cycle -> second operation completes N+1 cycles later.
REQ-036 rst_n pulsed low at RUN cycle 4 -> all outputs 0 immediately, no done; the next start gives the correct result.
REQ-037 WIDTH=4, DIGIT=2: exhaustive a, b, bin, mode -> each result matches REQ-020/REQ-021 with done 3 cycles after start.
